// File: rtl/mips_multicycle_ctrl_if.sv
// Signal bundle between the multicycle MIPS control FSM and its datapath.
// The controller takes the slave view; the datapath or testbench takes the master view.
interface mips_multicycle_ctrl_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] AluOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  modport slave (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, illegal_op, state
  );

  modport master (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j).
// Control outputs are decoded from the current state; memory steps wait on mem_ready.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_ctrl_if.slave     bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q;

  // State register and opcode latch; op is captured only while decoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= OP_W'(0);
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.Op;
    end
  end

  always_comb begin
    state_d         = S_FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.AluOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut receives PC + (imm << 2) as the speculative branch target.
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d        = S_FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.AluOp   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.AluOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class and compares
// the full control word each cycle against hand-written expected vectors.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  mips_multicycle_ctrl_if bif ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: state[3:0], PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  // MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], AluOp[1:0], PCSource[1:0], illegal_op
  localparam logic [20:0] V_FETCH1 = {4'd0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_FETCH0 = {4'd0, 10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_DEC    = {4'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_DECILL = {4'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [20:0] V_MEMADR = {4'd2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMRD  = {4'd3, 10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMWB  = {4'd4, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMWR  = {4'd5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_EXEC   = {4'd6, 10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [20:0] V_ALUWB  = {4'd7, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_BRANCH = {4'd8, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [20:0] V_JUMP   = {4'd9, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};

  function automatic logic [20:0] obs();
    return {bif.state, bif.PCWrite, bif.PCWriteCond, bif.IorD, bif.MemRead, bif.MemWrite,
            bif.IRWrite, bif.MemtoReg, bif.RegDst, bif.RegWrite, bif.ALUSrcA,
            bif.ALUSrcB, bif.AluOp, bif.PCSource, bif.illegal_op};
  endfunction

  // Apply inputs on the falling edge and let outputs settle before sampling.
  task automatic step(input logic mr, input logic [5:0] op);
    @(negedge clk);
    bif.mem_ready = mr;
    bif.Op        = op;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.mem_ready = 1'b1;
    bif.Op = 6'h04;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== V_FETCH1) $display("FAIL reset_hold got %h want %h", obs(), V_FETCH1);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== V_FETCH1) $display("FAIL reset_release got %h want %h", obs(), V_FETCH1);
    else passed++;
    step(1'b1, 6'h04);
    checks++;
    if (obs() !== V_DEC) $display("FAIL reset_decode got %h want %h", obs(), V_DEC);
    else passed++;
    step(1'b1, 6'h04);
    checks++;
    if (obs() !== V_BRANCH) $display("FAIL reset_branch got %h want %h", obs(), V_BRANCH);
    else passed++;
  endtask

  task automatic test_rtype();
    logic [20:0] ex [5];
    logic        mr [5];
    ex = '{V_FETCH0, V_FETCH1, V_DEC, V_EXEC, V_ALUWB};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(mr[i], 6'h00);
      checks++;
      if (obs() !== ex[i]) $display("FAIL rtype_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
  endtask

  task automatic test_lw_wait();
    logic [20:0] ex [7];
    logic        mr [7];
    ex = '{V_FETCH1, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step(mr[i], 6'h23);
      checks++;
      if (obs() !== ex[i]) $display("FAIL lw_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
  endtask

  // Op switches to lw after DECODE; the latched sw opcode must still select MEMWR.
  task automatic test_sw_op_change();
    logic [20:0] ex [4];
    logic [5:0]  op [4];
    ex = '{V_FETCH1, V_DEC, V_MEMADR, V_MEMWR};
    op = '{6'h2B, 6'h2B, 6'h23, 6'h23};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, op[i]);
      checks++;
      if (obs() !== ex[i]) $display("FAIL sw_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
  endtask

  task automatic test_beq_j();
    logic [20:0] ex [6];
    logic [5:0]  op [6];
    ex = '{V_FETCH1, V_DEC, V_BRANCH, V_FETCH1, V_DEC, V_JUMP};
    op = '{6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, op[i]);
      checks++;
      if (obs() !== ex[i]) $display("FAIL beqj_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] ex [3];
    ex = '{V_FETCH1, V_DECILL, V_FETCH1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'h3F);
      checks++;
      if (obs() !== ex[i]) $display("FAIL illegal_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] ex [4];
    logic        mr [4];
    ex = '{V_DEC, V_MEMADR, V_MEMRD, V_MEMRD};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0};
    // Entered from the FETCH cycle left by test_illegal.
    for (int i = 0; i < 4; i++) begin
      step(mr[i], 6'h23);
      checks++;
      if (obs() !== ex[i]) $display("FAIL rstmid_step%0d got %h want %h", i, obs(), ex[i]);
      else passed++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    step(1'b0, 6'h23);
    checks++;
    if (obs() !== V_FETCH0) $display("FAIL rstmid_fetch got %h want %h", obs(), V_FETCH0);
    else passed++;
    reset = 1'b0;
    step(1'b0, 6'h23);
    checks++;
    if (obs() !== V_FETCH0) $display("FAIL rstmid_wait got %h want %h", obs(), V_FETCH0);
    else passed++;
    step(1'b1, 6'h02);
    checks++;
    if (obs() !== V_FETCH1) $display("FAIL rstmid_fetch1 got %h want %h", obs(), V_FETCH1);
    else passed++;
    step(1'b1, 6'h02);
    checks++;
    if (obs() !== V_DEC) $display("FAIL rstmid_decode got %h want %h", obs(), V_DEC);
    else passed++;
    step(1'b1, 6'h02);
    checks++;
    if (obs() !== V_JUMP) $display("FAIL rstmid_jump got %h want %h", obs(), V_JUMP);
    else passed++;
    step(1'b1, 6'h02);
    checks++;
    if (obs() !== V_FETCH1) $display("FAIL rstmid_return got %h want %h", obs(), V_FETCH1);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    bif.mem_ready = 1'b0;
    bif.Op = 6'h00;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_op_change();
    test_beq_j();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
